// File: rtl/ef_spi_target_pkg.sv
// Shared definitions for the SPI target: frame width, engine states and
// the SCLK edge-select helper.
package ef_spi_target_pkg;

    localparam int SPI_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Picks the leading (leading=1) or trailing (leading=0) SCLK edge event
    // for the given idle polarity. With CPOL=0 the leading edge is the rise.
    function automatic logic edge_sel(input logic cpol, input logic leading,
                                      input logic rise, input logic fall);
        return (leading ^ cpol) ? rise : fall;
    endfunction

endpackage

// File: rtl/ef_spi_target_if.sv
// SPI pin bundle between an initiator (master) and this target (slave).
interface ef_spi_target_if;
    logic sclk;
    logic csb;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, csb, mosi, input miso, miso_oe);
    modport slave  (input sclk, csb, mosi, output miso, miso_oe);
endinterface

// File: rtl/ef_spi_target_fifo.sv
// Synchronous byte FIFO with show-ahead head, flush and occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle.
module ef_spi_target_fifo
    import ef_spi_target_pkg::*;
#(
    parameter int FAW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [SPI_DW-1:0] din,
    output logic [SPI_DW-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [FAW:0]      level
);
    localparam int            DEPTH   = 1 << FAW;
    localparam logic [FAW:0]  DEPTH_L = (FAW+1)'(DEPTH);

    logic [SPI_DW-1:0] mem [DEPTH];
    logic [FAW-1:0]    rptr, wptr;
    logic [FAW:0]      cnt;
    logic              do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == DEPTH_L);
    assign level   = cnt;
    assign dout    = mem[rptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer, count and storage update; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rptr <= wptr;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            cnt <= cnt + (FAW+1)'(do_push) - (FAW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ef_spi_target.sv
// SPI target core: oversampled pin synchronisers, CPOL/CPHA shift engine,
// and RX/TX byte FIFOs with level/threshold status.
module ef_spi_target
    import ef_spi_target_pkg::*;
#(
    parameter int              FAW  = 4,
    parameter logic [SPI_DW-1:0] FILL = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              enable,
    input  logic              rx_en,
    input  logic              wr,
    input  logic [SPI_DW-1:0] datai,
    input  logic              rd,
    output logic [SPI_DW-1:0] datao,
    input  logic              rx_flush,
    input  logic [FAW:0]      rx_threshold,
    output logic              rx_empty,
    output logic              rx_full,
    output logic              rx_level_above,
    output logic [FAW:0]      rx_level,
    input  logic              tx_flush,
    input  logic [FAW:0]      tx_threshold,
    output logic              tx_empty,
    output logic              tx_full,
    output logic              tx_level_below,
    output logic [FAW:0]      tx_level,
    output logic              busy,
    output logic              done,
    output logic              rx_overrun,
    output logic              tx_underrun,
    ef_spi_target_if.slave    spi
);
    localparam logic [2:0] LAST_BIT = 3'(SPI_DW - 1);

    logic [2:0]        sclk_s, csb_s;
    logic [1:0]        mosi_s;
    logic              sclk_rise, sclk_fall, lead_ev, trail_ev;
    logic              sample_ev, shift_ev, csb_fall, abort, byte_end;
    state_t            state, state_n;
    logic [SPI_DW-1:0] shift_reg, tx_head;
    logic [SPI_DW-2:0] rx_shift;
    logic [2:0]        bit_cnt;
    logic              need_load, tx_pop, rx_push;

    // Pin synchronisers; csb resets low so a frame cut by reset must see
    // CSB rise and fall again before it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s <= '0;
            csb_s  <= '0;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], spi.sclk};
            csb_s  <= {csb_s[1:0], spi.csb};
            mosi_s <= {mosi_s[0], spi.mosi};
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign lead_ev   = edge_sel(CPOL, 1'b1, sclk_rise, sclk_fall);
    assign trail_ev  = edge_sel(CPOL, 1'b0, sclk_rise, sclk_fall);
    assign sample_ev = CPHA ? trail_ev : lead_ev;
    assign shift_ev  = CPHA ? lead_ev : trail_ev;
    assign csb_fall  = csb_s[2] & ~csb_s[1];
    assign abort     = csb_s[1] | ~enable;
    assign byte_end  = (state == SHIFT) & ~abort & sample_ev & (bit_cnt == LAST_BIT);

    assign busy        = (state != IDLE);
    assign spi.miso    = shift_reg[SPI_DW-1];
    assign spi.miso_oe = busy;

    // Engine state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state plus the FIFO pop/push strobes issued by the engine.
    always_comb begin
        state_n = state;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        unique case (state)
            IDLE: if (csb_fall && enable) state_n = CPHA ? SHIFT : LOAD;
            LOAD: begin
                if (abort) state_n = IDLE;
                else begin
                    state_n = SHIFT;
                    tx_pop  = ~tx_empty;
                end
            end
            SHIFT: begin
                if (abort) state_n = IDLE;
                else begin
                    if (shift_ev && need_load) state_n = LOAD;
                    rx_push = byte_end & rx_en;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Shift registers, bit counter and status pulses. need_load marks that
    // the next shift edge loads a fresh byte instead of shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            need_load   <= 1'b0;
            done        <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            done        <= byte_end;
            rx_overrun  <= byte_end & rx_en & rx_full;
            tx_underrun <= (state == LOAD) & ~abort & tx_empty;
            if (state == IDLE) begin
                bit_cnt   <= '0;
                need_load <= CPHA;
            end else if (abort) begin
                bit_cnt   <= '0;
            end else if (state == LOAD) begin
                shift_reg <= tx_empty ? FILL : tx_head;
                need_load <= 1'b0;
            end else begin
                if (sample_ev) begin
                    rx_shift <= {rx_shift[SPI_DW-3:0], mosi_s[1]};
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) need_load <= 1'b1;
                end
                if (shift_ev && !need_load)
                    shift_reg <= {shift_reg[SPI_DW-2:0], 1'b0};
            end
        end
    end

    assign rx_level_above = (rx_level > rx_threshold);
    assign tx_level_below = (tx_level < tx_threshold);

    ef_spi_target_fifo #(.FAW(FAW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (rx_flush),
        .push  (rx_push),
        .pop   (rd),
        .din   ({rx_shift, mosi_s[1]}),
        .dout  (datao),
        .empty (rx_empty),
        .full  (rx_full),
        .level (rx_level)
    );

    ef_spi_target_fifo #(.FAW(FAW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (tx_flush),
        .push  (wr),
        .pop   (tx_pop),
        .din   (datai),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full),
        .level (tx_level)
    );

endmodule

// File: tb/tb_ef_spi_target.sv
// Bench for ef_spi_target: an SPI initiator drives frames, a frame-level
// model predicts MISO bytes, done/overrun/level events and RX contents,
// and a negedge monitor pops the expectations as the DUT produces them.
module tb_ef_spi_target;
    localparam int HP = 8;   // SCLK half period in clk cycles

    typedef struct {
        logic ovr;
        int   lvl;
    } done_t;

    logic       clk = 0, rst = 1;
    logic       cpol_r = 0, cpha_r = 0, enable = 1, rx_en = 1;
    logic       wr = 0, rd = 0, rx_flush = 0, tx_flush = 0;
    logic [7:0] datai = 0, datao;
    logic [4:0] rx_threshold = 5'd2, tx_threshold = 5'd2;
    logic [4:0] rx_level, tx_level;
    logic       rx_empty, rx_full, rx_level_above;
    logic       tx_empty, tx_full, tx_level_below;
    logic       busy, done, rx_overrun, tx_underrun;

    ef_spi_target_if spi_if();

    ef_spi_target dut (
        .clk(clk), .rst(rst), .CPOL(cpol_r), .CPHA(cpha_r), .enable(enable),
        .rx_en(rx_en), .wr(wr), .datai(datai), .rd(rd), .datao(datao),
        .rx_flush(rx_flush), .rx_threshold(rx_threshold), .rx_empty(rx_empty),
        .rx_full(rx_full), .rx_level_above(rx_level_above), .rx_level(rx_level),
        .tx_flush(tx_flush), .tx_threshold(tx_threshold), .tx_empty(tx_empty),
        .tx_full(tx_full), .tx_level_below(tx_level_below), .tx_level(tx_level),
        .busy(busy), .done(done), .rx_overrun(rx_overrun),
        .tx_underrun(tx_underrun), .spi(spi_if)
    );

    always #5 clk = ~clk;

    int         checks = 0, fails = 0;
    int         under_cnt = 0, exp_under = 0;
    logic [7:0] tx_m[$], rx_m[$], exp_miso_q[$];
    done_t      exp_done_q[$];
    logic [7:0] dbytes [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: assembles MISO at pin-level sample edges and checks done events.
    logic       prev_sclk = 0;
    int         mbits = 0;
    logic [7:0] mbyte = 0;
    always @(negedge clk) begin
        logic rise, fall, lead, trail, samp;
        done_t d;
        rise  = spi_if.sclk & ~prev_sclk;
        fall  = ~spi_if.sclk & prev_sclk;
        lead  = cpol_r ? fall : rise;
        trail = cpol_r ? rise : fall;
        samp  = cpha_r ? trail : lead;
        prev_sclk = spi_if.sclk;
        if (spi_if.csb) mbits = 0;
        else if (samp) begin
            chk("miso_oe", spi_if.miso_oe, 1'b1);
            mbyte = {mbyte[6:0], spi_if.miso};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_miso_q.size() == 0) chk("miso_unexpected_byte", 1, 0);
                else chk("miso_byte", mbyte, exp_miso_q.pop_front());
            end
        end
        if (tx_underrun) under_cnt++;
        if (rx_overrun && !done) chk("overrun_without_done", 1, 0);
        if (done) begin
            if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                d = exp_done_q.pop_front();
                chk("rx_overrun", rx_overrun, d.ovr);
                chk("rx_level_at_done", rx_level, d.lvl);
            end
        end
    end

    task automatic push_tx(input logic [7:0] b);
        wr = 1; datai = b;
        tick(1);
        wr = 0;
        if (tx_m.size() < 16) tx_m.push_back(b);
    endtask

    // Frame-level model: one TX load per byte, plus a trailing load after
    // the last byte when CPHA=0 (the final trailing edge is a shift edge).
    task automatic model_frame(input bit pha, input int n);
        for (int i = 0; i < n; i++) begin
            if (tx_m.size() > 0) exp_miso_q.push_back(tx_m.pop_front());
            else begin exp_miso_q.push_back(8'hFF); exp_under++; end
            if (rx_m.size() < 16) begin
                rx_m.push_back(dbytes[i]);
                exp_done_q.push_back('{ovr: 1'b0, lvl: rx_m.size()});
            end else exp_done_q.push_back('{ovr: 1'b1, lvl: 16});
        end
        if (!pha) begin
            if (tx_m.size() > 0) void'(tx_m.pop_front());
            else exp_under++;
        end
    endtask

    task automatic spi_frame(input bit pol, input bit pha, input int nbits, input bit do_rst);
        logic b;
        cpol_r = pol; cpha_r = pha; spi_if.sclk = pol;
        tick(HP);
        spi_if.csb = 0;
        if (!pha) spi_if.mosi = dbytes[0][7];
        tick(HP);
        for (int i = 0; i < nbits; i++) begin
            b = dbytes[i >> 3][7 - (i & 7)];
            if (pha) begin
                spi_if.sclk = ~pol; spi_if.mosi = b;
                tick(HP);
                spi_if.sclk = pol;
                tick(HP);
            end else begin
                spi_if.sclk = ~pol;
                tick(HP);
                spi_if.sclk = pol;
                if (i + 1 < nbits) spi_if.mosi = dbytes[(i+1) >> 3][7 - ((i+1) & 7)];
                tick(HP);
            end
        end
        if (do_rst) begin
            rst = 1;
            tick(1);
            chk("rst_busy", busy, 0);
            chk("rst_miso", spi_if.miso, 0);
            chk("rst_miso_oe", spi_if.miso_oe, 0);
            chk("rst_done", done, 0);
            chk("rst_flags", {rx_overrun, tx_underrun}, 0);
            chk("rst_levels", {rx_level, tx_level}, 0);
            chk("rst_empty", {rx_empty, tx_empty}, 2'b11);
            rst = 0;
            tick(HP);
        end
        spi_if.csb = 1;
        if (!do_rst) begin
            repeat (2) @(posedge clk); #1;
            chk("busy_before_csb_sync", busy, 1);
            @(posedge clk); #1;
            chk("busy_fall_3clk", busy, 0);
        end
        tick(HP);
    endtask

    task automatic post_frame();
        chk("underrun_count", under_cnt, exp_under);
        chk("tx_level", tx_level, tx_m.size());
        chk("tx_empty", tx_empty, tx_m.size() == 0);
        chk("tx_level_below", tx_level_below, tx_m.size() < 2);
        chk("rx_level", rx_level, rx_m.size());
        chk("pending_miso", exp_miso_q.size(), 0);
        chk("pending_done", exp_done_q.size(), 0);
    endtask

    task automatic drain_rx();
        while (rx_m.size() > 0) begin
            chk("rx_level_above", rx_level_above, rx_m.size() > 2);
            chk("datao", datao, rx_m.pop_front());
            rd = 1; tick(1); rd = 0;
        end
        chk("rx_empty_after_drain", rx_empty, 1);
        chk("rx_level_after_drain", rx_level, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, npre, m;
        spi_if.sclk = 0; spi_if.csb = 1; spi_if.mosi = 0;
        tick(3);
        chk("reset_busy", busy, 0);
        chk("reset_outs", {done, rx_overrun, tx_underrun, spi_if.miso, spi_if.miso_oe}, 0);
        chk("reset_rx", {rx_empty, rx_level}, {1'b1, 5'd0});
        chk("reset_tx", {tx_empty, tx_level}, {1'b1, 5'd0});
        chk("reset_datao", datao, 0);
        rst = 0;
        tick(4);

        // Mode 0 single byte
        push_tx(8'hA5);
        dbytes[0] = 8'h3C;
        model_frame(0, 1); spi_frame(0, 0, 8, 0); post_frame(); drain_rx();

        // Mode 3 two bytes, back to back
        push_tx(8'h12); push_tx(8'h34);
        dbytes[0] = 8'hF0; dbytes[1] = 8'h0F;
        model_frame(1, 2); spi_frame(1, 1, 16, 0); post_frame(); drain_rx();

        // Mode 1 with empty TX: FILL and one underrun
        dbytes[0] = 8'h5A;
        model_frame(1, 1); spi_frame(0, 1, 8, 0); post_frame(); drain_rx();

        // RX fill to 16 then overrun
        for (int i = 0; i < 16; i++) dbytes[i] = 8'($urandom);
        model_frame(1, 16); spi_frame(1, 1, 128, 0); post_frame();
        chk("rx_full", rx_full, 1);
        dbytes[0] = 8'hC3;
        model_frame(1, 1); spi_frame(1, 1, 8, 0); post_frame();
        drain_rx();

        // Partial frame (5 bits, mode 0) then a full frame
        push_tx(8'h66); push_tx(8'h99);
        dbytes[0] = 8'hE7;
        void'(tx_m.pop_front());
        spi_frame(0, 0, 5, 0); post_frame();
        dbytes[0] = 8'h81;
        model_frame(0, 1); spi_frame(0, 0, 8, 0); post_frame(); drain_rx();

        // Reset mid-byte, then a new frame, then rx_flush with wr
        push_tx(8'h55);
        void'(tx_m.pop_front());
        dbytes[0] = 8'hAA;
        spi_frame(0, 0, 3, 1);
        tx_m.delete(); rx_m.delete();
        post_frame();
        push_tx(8'h9C);
        dbytes[0] = 8'h6B;
        model_frame(0, 1); spi_frame(0, 0, 8, 0); post_frame();
        rx_flush = 1; wr = 1; datai = 8'h77;
        tick(1);
        rx_flush = 0; wr = 0;
        rx_m.delete(); tx_m.push_back(8'h77);
        chk("flush_rx_level", rx_level, 0);
        chk("flush_wr_tx_level", tx_level, tx_m.size());

        // Randomised frames
        for (int f = 0; f < 6; f++) begin
            m    = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            npre = $urandom_range(0, 3);
            for (int i = 0; i < npre; i++) push_tx(8'($urandom));
            for (int i = 0; i < n; i++) dbytes[i] = 8'($urandom);
            model_frame(m[0], n);
            spi_frame(m[1], m[0], n * 8, 0);
            post_frame();
            drain_rx();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
